// File: rtl/l1_set_assoc_cache.sv
// 2-way set-associative, write-back, write-allocate L1 data cache.
// Blocking: one CPU request at a time; 4-word lines refilled/evicted through a posted memory port.
module l1_set_assoc_cache #(
  parameter int INDEX_BITS = 8,
  parameter int ADDR_W     = 27,
  parameter int LINE_W     = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_req_addr_i,
  input  logic [31:0]       cpu_req_data_i,
  input  logic              cpu_req_rw_i,
  input  logic              cpu_req_valid_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_data_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [LINE_W-1:0] mem_req_data_o,
  output logic              mem_req_rw_o,
  output logic              mem_req_valid_o,
  output logic [31:0]       cpu_res_data_o,
  output logic              cpu_res_ready_o,
  output logic [2:0]        state_o
);
  localparam int SETS  = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - 2 - INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    COMPARE     = 3'd1,
    WRITEBACK   = 3'd2,
    ALLOCATE    = 3'd3,
    WAIT_REFILL = 3'd4,
    RESPOND     = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]          req_addr_q;
  logic [31:0]                req_data_q;
  logic                       req_rw_q;
  logic                       victim_q;
  logic [31:0]                res_data_q;
  logic [1:0][SETS-1:0]       valid_q;
  logic [1:0][SETS-1:0]       dirty_q;
  logic [SETS-1:0]            lru_q;
  logic [TAG_W-1:0]           tag_q  [2][SETS];
  logic [LINE_W-1:0]          data_q [2][SETS];

  logic [1:0]            req_off;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [1:0]            hit_w;
  logic                  hit, hit_way;
  logic [LINE_W-1:0]     hit_line;
  logic [31:0]           hit_word;
  logic                  vic_way, vic_dirty;

  assign req_off = req_addr_q[1:0];
  assign req_idx = req_addr_q[INDEX_BITS+1:2];
  assign req_tag = req_addr_q[ADDR_W-1:INDEX_BITS+2];

  assign hit_w[0] = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
  assign hit_w[1] = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
  assign hit      = |hit_w;
  assign hit_way  = hit_w[1];
  assign hit_line = data_q[hit_way][req_idx];
  assign hit_word = hit_line[{req_off, 5'b0} +: 32];

  // Invalid ways are filled before anything is evicted; way0 wins a tie.
  assign vic_way   = !valid_q[0][req_idx] ? 1'b0 :
                     !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
  assign vic_dirty = valid_q[vic_way][req_idx] && dirty_q[vic_way][req_idx];

  always_comb begin
    state_d         = state_q;
    mem_req_valid_o = 1'b0;
    mem_req_rw_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_data_o  = '0;
    cpu_res_ready_o = 1'b0;
    unique case (state_q)
      IDLE:    if (cpu_req_valid_i) state_d = COMPARE;
      COMPARE: begin
        if (hit)            state_d = RESPOND;
        else if (vic_dirty) state_d = WRITEBACK;
        else                state_d = ALLOCATE;
      end
      WRITEBACK: begin
        mem_req_valid_o = 1'b1;
        mem_req_rw_o    = 1'b1;
        mem_req_addr_o  = {tag_q[victim_q][req_idx], req_idx, 2'b00};
        mem_req_data_o  = data_q[victim_q][req_idx];
        state_d         = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {req_tag, req_idx, 2'b00};
        state_d         = WAIT_REFILL;
      end
      WAIT_REFILL: if (mem_data_ready_i) state_d = COMPARE;
      RESPOND: begin
        cpu_res_ready_o = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_rw_q   <= 1'b0;
      victim_q   <= 1'b0;
      res_data_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      lru_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cpu_req_valid_i) begin
        req_addr_q <= cpu_req_addr_i;
        req_data_q <= cpu_req_data_i;
        req_rw_q   <= cpu_req_rw_i;
      end
      if (state_q == COMPARE) begin
        if (hit) begin
          lru_q[req_idx] <= ~hit_way;
          res_data_q     <= req_rw_q ? req_data_q : hit_word;
          if (req_rw_q) dirty_q[hit_way][req_idx] <= 1'b1;
        end else begin
          victim_q <= vic_way;
        end
      end
      if (state_q == WAIT_REFILL && mem_data_ready_i) begin
        valid_q[victim_q][req_idx] <= 1'b1;
        dirty_q[victim_q][req_idx] <= 1'b0;
      end
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == COMPARE && hit && req_rw_q)
        data_q[hit_way][req_idx][{req_off, 5'b0} +: 32] <= req_data_q;
      if (state_q == WAIT_REFILL && mem_data_ready_i) begin
        data_q[victim_q][req_idx] <= mem_data_i;
        tag_q[victim_q][req_idx]  <= req_tag;
      end
    end
  end

  assign cpu_res_data_o = res_data_q;
  assign state_o        = state_q;
endmodule

// File: tb/tb_l1_set_assoc_cache.sv
// Scoreboarded bench for l1_set_assoc_cache: expected memory requests and CPU responses
// are queued as stimulus is issued and checked as the DUT emits them.
module tb_l1_set_assoc_cache;
  localparam int MEM_LAT = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [26:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic         cpu_rw = 1'b0;
  logic         cpu_valid = 1'b0;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
  logic [26:0]  mreq_addr;
  logic [127:0] mreq_data;
  logic         mreq_rw, mreq_valid;
  logic [31:0]  res_data;
  logic         res_ready;
  logic [2:0]   state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [26:0]  a;
    logic         rw;
    logic [127:0] d;
  } mreq_t;

  mreq_t        exp_mreq_q[$];
  logic [31:0]  exp_res_q[$];
  logic [127:0] mem_m [logic [26:0]];

  l1_set_assoc_cache dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_addr_i(cpu_addr), .cpu_req_data_i(cpu_wdata),
    .cpu_req_rw_i(cpu_rw), .cpu_req_valid_i(cpu_valid),
    .mem_data_i(mem_rdata), .mem_data_ready_i(mem_ready),
    .mem_req_addr_o(mreq_addr), .mem_req_data_o(mreq_data),
    .mem_req_rw_o(mreq_rw), .mem_req_valid_o(mreq_valid),
    .cpu_res_data_o(res_data), .cpu_res_ready_o(res_ready),
    .state_o(state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(logic [26:0] a, int i);
    logic [1:0] o;
    o = i[1:0];
    return 32'hC000_0000 ^ {3'b000, a, o};
  endfunction

  function automatic logic [127:0] init_line(logic [26:0] a);
    return {init_word(a, 3), init_word(a, 2), init_word(a, 1), init_word(a, 0)};
  endfunction

  function automatic logic [127:0] mem_line(logic [26:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return init_line(a);
  endfunction

  task automatic exp_mreq(input logic [26:0] a, input logic rw, input logic [127:0] d);
    mreq_t m;
    m.a = a; m.rw = rw; m.d = d;
    exp_mreq_q.push_back(m);
  endtask

  // Scoreboard: memory requests and CPU responses, sampled mid-cycle.
  always @(negedge clk) begin
    if (mreq_valid) begin
      checks++;
      if (exp_mreq_q.size() == 0) begin
        errors++;
        $display("FAIL mem_req unexpected: addr=%h rw=%0d", mreq_addr, mreq_rw);
      end else begin
        mreq_t e;
        e = exp_mreq_q.pop_front();
        if (mreq_addr !== e.a || mreq_rw !== e.rw || (e.rw && mreq_data !== e.d)) begin
          errors++;
          $display("FAIL mem_req: got addr=%h rw=%0d data=%h want addr=%h rw=%0d data=%h",
                   mreq_addr, mreq_rw, mreq_data, e.a, e.rw, e.d);
        end
      end
      if (mreq_rw) mem_m[mreq_addr] = mreq_data;
    end
    if (res_ready) begin
      checks++;
      if (exp_res_q.size() == 0) begin
        errors++;
        $display("FAIL cpu_res unexpected: data=%h", res_data);
      end else begin
        logic [31:0] e;
        e = exp_res_q.pop_front();
        if (res_data !== e) begin
          errors++;
          $display("FAIL cpu_res data: got %h want %h", res_data, e);
        end
      end
    end
  end

  // Memory responder: fixed-latency refill of read requests.
  always begin
    logic [26:0] a;
    @(negedge clk);
    if (mreq_valid && !mreq_rw) begin
      a = mreq_addr;
      repeat (MEM_LAT) @(posedge clk);
      #1;
      mem_rdata = mem_line(a);
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
    end
  end

  // exp_lat counts negedges from issue to the ready pulse; 0 skips the latency check.
  task automatic cpu_op(input logic [26:0] a, input logic rw, input logic [31:0] d,
                        input logic [31:0] exp, input int exp_lat);
    int  n;
    bit  got;
    exp_res_q.push_back(exp);
    @(posedge clk);
    #1;
    cpu_addr = a; cpu_rw = rw; cpu_wdata = d; cpu_valid = 1'b1;
    n = 0; got = 0;
    while (n < 300 && !got) begin
      @(negedge clk);
      n++;
      if (res_ready) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL cpu_op timeout: addr=%h got no ready want ready", a);
      exp_res_q.delete();
    end else if (exp_lat > 0) begin
      checks++;
      if (n != exp_lat) begin
        errors++;
        $display("FAIL latency addr=%h: got %0d want %0d", a, n, exp_lat);
      end
    end
    @(posedge clk);
    #1;
    cpu_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || res_ready !== 1'b0 || res_data !== 32'h0) begin
      errors++;
      $display("FAIL reset cpu side: got state=%0d ready=%0d data=%h want 0 0 0", state, res_ready, res_data);
    end
    checks++;
    if (mreq_valid !== 1'b0 || mreq_rw !== 1'b0 || mreq_addr !== 27'h0 || mreq_data !== 128'h0) begin
      errors++;
      $display("FAIL reset mem side: got v=%0d rw=%0d a=%h d=%h want zeros", mreq_valid, mreq_rw, mreq_addr, mreq_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    exp_mreq(27'h0AAAAA8, 1'b0, '0);
    cpu_op(27'h0AAAAAA, 1'b1, 32'h3333_3333, 32'h3333_3333, 7);
  endtask

  task automatic test_hit();
    cpu_op(27'h0AAAAAA, 1'b0, '0, 32'h3333_3333, 3);
    cpu_op(27'h0AAAAAB, 1'b1, 32'h1C71_C71C, 32'h1C71_C71C, 3);
    cpu_op(27'h0AAAAAB, 1'b0, '0, 32'h1C71_C71C, 3);
    cpu_op(27'h0AAAAA8, 1'b0, '0, init_word(27'h0AAAAA8, 0), 3);
    cpu_op(27'h0AAAAA9, 1'b0, '0, init_word(27'h0AAAAA8, 1), 3);
  endtask

  task automatic test_second_way();
    exp_mreq(27'h62AAAA8, 1'b0, '0);
    cpu_op(27'h62AAAAA, 1'b1, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 7);
    cpu_op(27'h62AAAAA, 1'b0, '0, 32'h0F0F_0F0F, 3);
    cpu_op(27'h0AAAAAA, 1'b0, '0, 32'h3333_3333, 3);
  endtask

  task automatic test_word_merge();
    logic [31:0] wv [3];
    int          wo [3];
    wv = '{32'hABCD_EF33, 32'hABCD_EF11, 32'hABCD_EF00};
    wo = '{0, 1, 3};
    for (int i = 0; i < 3; i++) begin
      cpu_op(27'h62AAAA8 + 27'(wo[i]), 1'b1, wv[i], wv[i], 3);
      cpu_op(27'h62AAAA8 + 27'(wo[i]), 1'b0, '0, wv[i], 3);
    end
    cpu_op(27'h62AAAAA, 1'b0, '0, 32'h0F0F_0F0F, 3);
  endtask

  task automatic test_dirty_evict();
    exp_mreq(27'h0AAAAA8, 1'b1, {32'h1C71_C71C, 32'h3333_3333,
                                 init_word(27'h0AAAAA8, 1), init_word(27'h0AAAAA8, 0)});
    exp_mreq(27'h7EAAAA8, 1'b0, '0);
    cpu_op(27'h7EAAAAA, 1'b1, 32'hAAAA_BBBB, 32'hAAAA_BBBB, 8);
    cpu_op(27'h7EAAAAA, 1'b0, '0, 32'hAAAA_BBBB, 3);
  endtask

  task automatic test_reset_abort();
    int n;
    exp_mreq(27'h62AAAA8, 1'b1, {32'hABCD_EF00, 32'h0F0F_0F0F, 32'hABCD_EF11, 32'hABCD_EF33});
    exp_mreq(27'h02AAAA8, 1'b0, '0);
    @(posedge clk);
    #1;
    cpu_addr = 27'h02AAAAA; cpu_rw = 1'b0; cpu_valid = 1'b1;
    n = 0;
    while (n < 100 && state !== 3'd4) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL reach WAIT_REFILL: got state %0d want 4", state);
    end
    @(posedge clk);
    #1;
    rst = 1'b1; cpu_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || res_ready !== 1'b0 || mreq_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort reset: got state=%0d ready=%0d mreq_v=%0d want 0 0 0", state, res_ready, mreq_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    checks++;
    if (exp_mreq_q.size() != 0) begin
      errors++;
      $display("FAIL abort mem_req drained: got %0d pending want 0", exp_mreq_q.size());
      exp_mreq_q.delete();
    end
    // Everything now misses; memory holds only the written-back lines.
    exp_mreq(27'h0AAAAA8, 1'b0, '0);
    cpu_op(27'h0AAAAAA, 1'b0, '0, 32'h3333_3333, 7);
    cpu_op(27'h0AAAAA9, 1'b0, '0, init_word(27'h0AAAAA8, 1), 3);
    exp_mreq(27'h62AAAA8, 1'b0, '0);
    cpu_op(27'h62AAAAA, 1'b0, '0, 32'h0F0F_0F0F, 7);
    exp_mreq(27'h7EAAAA8, 1'b0, '0);
    cpu_op(27'h7EAAAAA, 1'b0, '0, init_word(27'h7EAAAA8, 2), 7);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_second_way();
    test_word_merge();
    test_dirty_evict();
    test_reset_abort();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_mreq_q.size() != 0 || exp_res_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drained: got mreq=%0d res=%0d pending want 0 0",
               exp_mreq_q.size(), exp_res_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
